// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with Mealy match flag, run-time pattern
// reload and overlap select. Optional saturating match counter: SEQ_DET_MATCH_CNT_EN.
module seq_detect_param #(
  parameter int unsigned N       = 4,
  parameter logic [N-1:0] PATTERN = N'(4'b1101),
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             mode_overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             y,
  output logic             busy_fill,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FW = $clog2(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

  logic [N-2:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic [N-1:0]  r_pat;
  logic [N-1:0]  w_window;
  logic          w_armed;
  logic          w_hit;

  // Candidate window: held history followed by the bit on the wire this cycle.
  assign w_window = {r_hist, din};
  assign w_armed  = (r_fill == FILL_FULL);
  assign w_hit    = ~reset & din_valid & ~pat_load & w_armed & (w_window == r_pat);

  assign y         = w_hit;
  assign busy_fill = reset | ~w_armed;

  // History, fill level and pattern register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= PATTERN;
    end else if (pat_load) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= pat_in;
    end else if (din_valid) begin
      r_hist <= w_window[N-2:0];
      // Non-overlapping hit consumes the history so the next match needs N fresh bits.
      if (w_hit && !mode_overlap) begin
        r_fill <= '0;
      end else if (!w_armed) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating hit counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = reset ? CNT_W'(0) : r_cnt;
`else
  assign match_cnt = CNT_W'(0);
`endif

endmodule
